// File: rtl/muldiv_pkg.sv
// rtl/muldiv_pkg.sv - shared encodings and constants for the multiply/divide unit
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    localparam logic [31:0] DIV0_QUOT = 32'hFFFF_FFFF;

    function automatic logic is_iter_op(input logic [2:0] op);
        return (op <= 3'd3);
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// rtl/muldiv_if.sv - request/result bundle between controller and multiply/divide unit
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (output start, op, op_a, op_b, input busy, done, hi, lo);
    modport slave  (input start, op, op_a, op_b, output busy, done, hi, lo);
endinterface

// File: rtl/muldiv_abs_neg.sv
// rtl/muldiv_abs_neg.sv - conditional two's-complement negate
module muldiv_abs_neg #(
    parameter int W = 32
) (
    input  logic [W-1:0] val_i,
    input  logic         neg_i,
    output logic [W-1:0] res_o
);
    assign res_o = neg_i ? -val_i : val_i;
endmodule

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - radix-2 iterative multiply/divide unit owning HI/LO
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic    clk,
    input  logic    rst,
    muldiv_if.slave bus
);

    state_e             state_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q;
    logic [WIDTH-1:0]   hi_q, lo_q, hi_d, lo_d;
    logic               is_div_q, neg_prod_q, neg_rem_q, div0_q;
    logic               busy_q, done_q;

    logic               is_signed;
    logic [WIDTH-1:0]   abs_a, abs_b, quot_fix, rem_fix;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;

    assign is_signed = (bus.op == OP_MULT) || (bus.op == OP_DIV);

    muldiv_abs_neg #(.W(WIDTH)) u_abs_a (
        .val_i(bus.op_a), .neg_i(is_signed & bus.op_a[WIDTH-1]), .res_o(abs_a));
    muldiv_abs_neg #(.W(WIDTH)) u_abs_b (
        .val_i(bus.op_b), .neg_i(is_signed & bus.op_b[WIDTH-1]), .res_o(abs_b));

    // The quotient shares the product's sign rule; the remainder follows the dividend.
    muldiv_abs_neg #(.W(2*WIDTH)) u_prod_fix (
        .val_i(acc_q), .neg_i(neg_prod_q), .res_o(prod_fix));
    muldiv_abs_neg #(.W(WIDTH)) u_quot_fix (
        .val_i(acc_q[WIDTH-1:0]), .neg_i(neg_prod_q), .res_o(quot_fix));
    muldiv_abs_neg #(.W(WIDTH)) u_rem_fix (
        .val_i(acc_q[2*WIDTH-1:WIDTH]), .neg_i(neg_rem_q), .res_o(rem_fix));

    // acc_q holds {partial, multiplier} for MULT and {remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
        rem_sh  = acc_q[2*WIDTH-1:WIDTH-1];
        diff    = rem_sh - {1'b0, opnd_q};
        if (is_div_q) begin
            acc_d = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                : {diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
            hi_d  = rem_fix;
            lo_d  = div0_q ? DIV0_QUOT[WIDTH-1:0] : quot_fix;
        end else begin
            acc_d = {mul_sum, acc_q[WIDTH-1:1]};
            hi_d  = prod_fix[2*WIDTH-1:WIDTH];
            lo_d  = prod_fix[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            acc_q      <= '0;
            opnd_q     <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            is_div_q   <= 1'b0;
            neg_prod_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            div0_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start && is_iter_op(bus.op)) begin
                        acc_q      <= {{WIDTH{1'b0}}, abs_a};
                        opnd_q     <= abs_b;
                        is_div_q   <= bus.op[1];
                        neg_prod_q <= is_signed & (bus.op_a[WIDTH-1] ^ bus.op_b[WIDTH-1]);
                        neg_rem_q  <= is_signed & bus.op_a[WIDTH-1];
                        div0_q     <= (bus.op_b == '0);
                        cnt_q      <= '0;
                        busy_q     <= 1'b1;
                        state_q    <= ST_RUN;
                    end else if (bus.start && bus.op == OP_MTHI) begin
                        hi_q <= bus.op_a;
                    end else if (bus.start && bus.op == OP_MTLO) begin
                        lo_q <= bus.op_a;
                    end
                end
                ST_RUN: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_q <= ST_FIX;
                end
                ST_FIX: begin
                    hi_q    <= hi_d;
                    lo_q    <= lo_d;
                    done_q  <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit
module tb_muldiv_unit;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(32)) bus();
    muldiv_unit #(.WIDTH(32), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Result as {hi, lo}, straight from the arithmetic definition of each op.
    function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint     sa, sb, sq, sr;
        logic [63:0] ua, ub, res;
        sa = $signed(a);
        sb = $signed(b);
        ua = {32'd0, a};
        ub = {32'd0, b};
        res = '0;
        case (op)
            3'd0: begin sq = sa * sb; res = sq; end
            3'd1: res = ua * ub;
            3'd2: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else begin
                    sq = sa / sb;
                    sr = sa % sb;
                    res = {sr[31:0], sq[31:0]};
                end
            end
            3'd3: begin
                if (b == 0) res = {a, 32'hFFFF_FFFF};
                else res = {ua[31:0] % ub[31:0], ua[31:0] / ub[31:0]};
            end
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        @(negedge clk);
        bus.start = 1'b1; bus.op = op; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 3'($urandom); bus.op_a = $urandom; bus.op_b = $urandom;
    endtask

    task automatic wait_done(input int inj, output int cyc);
        int guard;
        cyc = 0;
        guard = 0;
        while (bus.done !== 1'b1 && guard < 100) begin
            if (bus.busy === 1'b1) cyc++;
            bus.start = (cyc == inj);
            if (cyc == inj) begin
                bus.op = 3'd3; bus.op_a = $urandom; bus.op_b = $urandom;
            end
            @(negedge clk);
            guard++;
        end
        bus.start = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [2:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [63:0] exp, input int inj);
        int cyc;
        issue(op, a, b);
        wait_done(inj, cyc);
        check({tag, "_done"}, bus.done, 1);
        check({tag, "_busy_cycles"}, cyc, 33);
        check({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
        check({tag, "_busy_at_done"}, bus.busy, 0);
        @(negedge clk);
        check({tag, "_done_pulse"}, bus.done, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        int cyc, gap, extra;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] exp;

        bus.start = 1'b0; bus.op = '0; bus.op_a = '0; bus.op_b = '0;

        repeat (4) begin
            @(negedge clk);
            bus.start = 1'($urandom); bus.op = 3'($urandom);
            bus.op_a = $urandom; bus.op_b = $urandom;
        end
        check("rst_hi", bus.hi, 0);
        check("rst_lo", bus.lo, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        bus.start = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        run_op("multu_max", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, -1);
        run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 64'hFFFF_FFFF_FFFF_FFEB, 5);
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        check("busy_start_ignored", extra, 0);
        check("mult_neg_held", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFEB);

        run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD, -1);
        run_op("divu", 3'd3, 32'd100, 32'd7, {32'd2, 32'd14}, -1);
        run_op("divu_zero", 3'd3, 32'h0000_1234, 32'd0, 64'h0000_1234_FFFF_FFFF, -1);
        run_op("div_zero_neg", 3'd2, 32'h8000_0005, 32'd0, 64'h8000_0005_FFFF_FFFF, -1);
        run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, -1);

        @(negedge clk);
        bus.start = 1'b1; bus.op = 3'd4; bus.op_a = 32'hDEAD_BEEF;
        @(negedge clk);
        check("mthi_hi", bus.hi, 32'hDEAD_BEEF);
        check("mthi_busy", bus.busy, 0);
        bus.op = 3'd5; bus.op_a = 32'h0BAD_F00D;
        @(negedge clk);
        bus.start = 1'b0;
        check("mtlo_lo", bus.lo, 32'h0BAD_F00D);
        check("mtlo_hi_kept", bus.hi, 32'hDEAD_BEEF);
        check("mtlo_busy_done", {bus.busy, bus.done}, 0);

        bus.start = 1'b1; bus.op = 3'd6; bus.op_a = $urandom;
        @(negedge clk);
        bus.op = 3'd7; bus.op_a = $urandom;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        check("reserved_hilo", {bus.hi, bus.lo}, 64'hDEAD_BEEF_0BAD_F00D);
        check("reserved_busy", bus.busy, 0);

        a = $urandom; b = $urandom;
        issue(3'd1, a, b);
        wait_done(-1, cyc);
        check("b2b_first_done", bus.done, 1);
        check("b2b_first_hilo", {bus.hi, bus.lo}, model(3'd1, a, b));
        a = $urandom; b = $urandom;
        bus.start = 1'b1; bus.op = 3'd1; bus.op_a = a; bus.op_b = b;
        @(negedge clk);
        bus.start = 1'b0; bus.op_a = $urandom; bus.op_b = $urandom;
        gap = 1;
        while (bus.done !== 1'b1 && gap < 100) begin
            @(negedge clk);
            gap++;
        end
        check("b2b_gap", gap, 34);
        check("b2b_second_hilo", {bus.hi, bus.lo}, model(3'd1, a, b));

        repeat (16) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'hFFFF_FFFF;
                2:       b = $urandom_range(1, 15);
                default: b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            exp = model(op, a, b);
            run_op($sformatf("rand_op%0d", op), op, a, b, exp, -1);
        end

        issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (9) @(negedge clk);
        rst = 1'b0;
        #1;
        check("midrst_hilo", {bus.hi, bus.lo}, 0);
        check("midrst_busy_done", {bus.busy, bus.done}, 0);
        @(negedge clk);
        rst = 1'b1;
        extra = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        check("midrst_no_done", extra, 0);
        check("midrst_hilo_held", {bus.hi, bus.lo}, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multiply/divide unit in the execute stage, directly downstream of the register file.
- Consumes the two register read ports (rdata_A, rdata_B) as operands and owns the architectural HI/LO registers for MULT/MULTU/DIV/DIVU/MTHI/MTLO.
- Uses a radix-2, one-bit-per-cycle datapath with a start/busy/done handshake so the controller stalls while an operation is running.
- HI/LO values feed the MFHI/MFLO path back to register-file writeback.

Parameters:
- WIDTH, 32, operand width and HI/LO width.
- CNT_W, 5, iteration counter width; must equal log2(WIDTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- start  in  1  op request, sampled on rising clk.
- op  in  3  0=MULT 1=MULTU 2=DIV 3=DIVU 4=MTHI 5=MTLO; 6,7 reserved.
- op_a  in  WIDTH  operand A (multiplicand/dividend, or MTHI/MTLO data), from rdata_A.
- op_b  in  WIDTH  operand B (multiplier/divisor), from rdata_B.
- busy  out  1  high while an iterative op is in flight.
- done  out  1  one-cycle pulse when HI/LO commit an iterative result.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, hi=0, lo=0, busy=0, done=0, counter=0.
- Reset mid-operation aborts the op; no partial commit.
- States:
  - IDLE: start=1 with op 0-3 latches |op_a|, |op_b|, sign flags and op → RUN, counter=0.
  - IDLE: start=1 with op 4 (MTHI) writes hi<=op_a; op 5 (MTLO) writes lo<=op_a; single edge, stays IDLE, busy/done stay 0.
  - IDLE: reserved op is ignored.
  - RUN: one shift-add (mult) or restoring shift-subtract (div) step per cycle. counter increments; after the step at counter=WIDTH-1 → FIX.
  - FIX: apply sign correction, commit hi/lo, assert done for the following cycle → IDLE.
- Timing: start sampled at edge E0; busy=1 after E0 through E(WIDTH+1); hi/lo update at E(WIDTH+1)=E33. done=1 and busy=0 in the cycle after E33.
- Handshake:
  - start while busy=1 is ignored; operands are not re-latched.
  - A new start is accepted in the same cycle that done=1.
  - op_a/op_b may change freely after E0.
- Mult result: 64-bit product; hi=[63:32], lo=[31:0]. Signed mode uses two's-complement magnitudes; negate the 64-bit product if the signs differ.
- Div result: lo=quotient, hi=remainder. Signed mode: quotient negated if signs differ; remainder takes the dividend's sign.
- Divide by zero (op_b=0, both DIV and DIVU): lo=32'hFFFF_FFFF, hi=op_a unchanged; full latency; done asserted.
- Signed overflow (DIV 0x8000_0000 / 0xFFFF_FFFF): lo=0x8000_0000, hi=0.
- MTHI/MTLO while busy=1: ignored, because start is ignored while busy.
- hi/lo hold their value at all times except at commit, MTHI/MTLO, or reset.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings (OP_MULT..OP_MTLO);
  - state encoding (ST_IDLE, ST_RUN, ST_FIX);
  - DIV0_QUOT constant (all-ones).
- One natural sub-module: muldiv_abs_neg, a combinational conditional two's-complement negate, instantiated for operand magnitude and result correction.

Test Plan:
- Reset: hold rst=0 with random inputs → hi=0, lo=0, busy=0, done=0. Assert rst=0 at RUN cycle 10 of a MULTU → hi/lo=0 and IDLE immediately; no done after release.
- MULTU 0xFFFF_FFFF × 0xFFFF_FFFF → at E33 hi=0xFFFF_FFFE, lo=0x0000_0001; busy high exactly 33 cycles; single done pulse.
- MULT -3 (0xFFFF_FFFD) × 7 → hi=0xFFFF_FFFF, lo=0xFFFF_FFEB. A start issued during busy with op=DIVU is ignored: result unchanged, no second done.
- DIV -7 / 2 → lo=0xFFFF_FFFD, hi=0xFFFF_FFFF. DIVU 100 / 7 → lo=14, hi=2.
- DIVU 0x1234 / 0 → lo=0xFFFF_FFFF, hi=0x1234. DIV 0x8000_0000 / 0xFFFF_FFFF → lo=0x8000_0000, hi=0.
- MTHI 0xDEAD_BEEF then MTLO 0x0BAD_F00D on consecutive cycles → hi/lo update one edge each; busy and done stay 0. Back-to-back MULTU started in the done cycle → accepted; second done 34 cycles after the first.
